// File: rtl/div_sched.sv
// div_sched: round-robin arbiter sharing one iterative divider core among NREQ requesters.
// Latency: grant in cycle 0, core start in cycle 1, response the cycle after core ready (cycle 1 for bad operands).
// Backpressure: one transaction in flight; the response is held until rsp_ready and no grant is made meanwhile.
// Optional feature: define DIV_SCHED_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT cycles.

module div_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 32,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              div_start,
  output logic [W-1:0]      div_a,
  output logic [W-1:0]      div_b,
  input  logic              div_ready,
  input  logic [W-1:0]      div_q,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_q,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [W-1:0]    div_a_q, div_b_q, rsp_q_q;
  logic            rsp_err_q;

  logic            gnt_vld;
  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic [W-1:0]    sel_a, sel_b;
  logic            sel_norm;
  logic            wait_to;

  // Round-robin pick: first requester after the last one served, wrapping around.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_oh  = '0;
    gnt_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && (i == (int'(rr_ptr_q) + k) % NREQ) && req_valid[i]) begin
          gnt_vld   = 1'b1;
          gnt_oh[i] = 1'b1;
          gnt_idx   = IDW'(i);
        end
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // The core assumes both operands are in .1xxx form; anything else is bounced.
  assign sel_norm = sel_a[W-1] & sel_b[W-1];

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt_q;

  // WAIT-cycle counter: zero outside WAIT, saturates instead of wrapping.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wcnt_q <= '0;
    end else if (state_q != S_WAIT) begin
      wcnt_q <= '0;
    end else if (wcnt_q != CW'(TIMEOUT)) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign wait_to = (wcnt_q == CW'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign wait_to        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_vld) state_d = sel_norm ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (div_ready || wait_to) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs; the accept pulse is suppressed while reset is held.
  always_comb begin
    req_ready = '0;
    div_start = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      S_IDLE:  if (!clr) req_ready = gnt_oh;
      S_ISSUE: div_start = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, pointer and response registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rr_ptr_q  <= IDW'(NREQ - 1);
      rsp_id_q  <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      rsp_q_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && gnt_vld) begin
        rr_ptr_q  <= gnt_idx;
        rsp_id_q  <= gnt_idx;
        div_a_q   <= sel_a;
        div_b_q   <= sel_b;
        rsp_q_q   <= '0;
        rsp_err_q <= ~sel_norm;
      end
      if (state_q == S_WAIT) begin
        if (div_ready) begin
          rsp_q_q   <= div_q;
          rsp_err_q <= 1'b0;
        end else if (wait_to) begin
          rsp_q_q   <= '0;
          rsp_err_q <= 1'b1;
        end
      end
    end
  end

  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign rsp_id  = rsp_id_q;
  assign rsp_q   = rsp_q_q;
  assign rsp_err = rsp_err_q;

endmodule
